// File: rtl/gnrl_arb_pkg.sv
// Shared definitions for the general-purpose arbiters: lock-state encoding
// and the modulo-N pointer rotation helper.
package gnrl_arb_pkg;

  localparam logic IDLE   = 1'b0;
  localparam logic LOCKED = 1'b1;

  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned n);
    return (ptr >= n - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/gnrl_dfflrs.sv
// Reset-DFF primitive: load-enable register with synchronous active-low reset.
module gnrl_dfflrs #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)  q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/gnrl_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N, found by a priority scan over a doubled request vector.
module gnrl_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic           found;

  always_comb begin
    dbl   = {req, req};
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!found && (j >= int'(ptr)) && (j < int'(ptr) + N) && dbl[j]) begin
        found        = 1'b1;
        idx          = IW'(j % N);
        gnt[j % N]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gnrl_rr_arb.sv
// Registered round-robin arbiter with packet locking: N valid/ready sources
// share one downstream port through a single output register.
module gnrl_rr_arb
  import gnrl_arb_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int DW = 32,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_valid,
  output logic [N-1:0]  i_ready,
  input  logic [N*DW-1:0] i_data,
  input  logic [N-1:0]  i_last,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic          o_last,
  output logic [IW-1:0] o_id
);

  logic          state;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] rr_ptr_nxt;

  logic          adv;
  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  gnt;
  logic [IW-1:0] acc_idx;
  logic          acc;
  logic          acc_last;
  logic [DW-1:0] acc_data;

  gnrl_rr_pick #(.N(N)) u_pick (
    .req (i_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign adv = ~o_valid | o_ready;

  // While locked only the owner may be granted; an idle owner leaves a bubble.
  always_comb begin
    gnt     = (state == LOCKED) ? ((N'(1) << owner) & i_valid) : pick_gnt;
    acc_idx = (state == LOCKED) ? owner : pick_idx;
  end

  assign i_ready = rst_n ? (gnt & {N{adv}}) : '0;
  assign acc     = |(i_valid & i_ready);

  always_comb begin
    acc_data = '0;
    acc_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (acc_idx == IW'(i)) begin
        acc_data = i_data[i*DW +: DW];
        acc_last = i_last[i];
      end
    end
  end

  assign rr_ptr_nxt = IW'(wrap_inc(32'(acc_idx), N));

  // Output stage: valid follows every advance, payload only loads on accept.
  gnrl_dfflrs #(.W(1)) u_o_valid (
    .clk (clk), .rst_n (rst_n), .en (adv), .d (acc), .q (o_valid)
  );

  gnrl_dfflrs #(.W(DW + 1 + IW)) u_o_beat (
    .clk (clk), .rst_n (rst_n), .en (acc),
    .d ({acc_data, acc_last, acc_idx}), .q ({o_data, o_last, o_id})
  );

  gnrl_dfflrs #(.W(1)) u_state (
    .clk (clk), .rst_n (rst_n), .en (acc),
    .d (acc_last ? IDLE : LOCKED), .q (state)
  );

  gnrl_dfflrs #(.W(IW)) u_owner (
    .clk (clk), .rst_n (rst_n), .en (acc & ~acc_last), .d (acc_idx), .q (owner)
  );

  gnrl_dfflrs #(.W(IW)) u_rr_ptr (
    .clk (clk), .rst_n (rst_n), .en (acc & acc_last), .d (rr_ptr_nxt), .q (rr_ptr)
  );

endmodule
